// File: rtl/eth_pkg.sv
// Shared constants, parser state encoding and byte-select helpers for the
// MAC-control PAUSE receive path.
package eth_pkg;

    localparam logic [47:0] PAUSE_DA       = 48'h0180C2000001;
    localparam logic [15:0] ETYPE_MAC_CTRL = 16'h8808;
    localparam logic [15:0] OPC_PAUSE      = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_DROP  = 2'd2
    } rx_state_t;

    // Byte n of a MAC address as it appears on the wire (MSB first).
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] n);
        logic [7:0] b;
        case (n)
            3'd0:    b = addr[47:40];
            3'd1:    b = addr[39:32];
            3'd2:    b = addr[31:24];
            3'd3:    b = addr[23:16];
            3'd4:    b = addr[15:8];
            3'd5:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Expected byte at frame offsets 12..15: ethertype then opcode.
    function automatic logic [7:0] hdr_byte(input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = ETYPE_MAC_CTRL[15:8];
            2'd1:    b = ETYPE_MAC_CTRL[7:0];
            2'd2:    b = OPC_PAUSE[15:8];
            default: b = OPC_PAUSE[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pause_timer.sv
// Holds an accepted pause request until the transmitter is between frames,
// then counts the requested quanta down through a per-quantum prescaler.
module pause_timer #(
    parameter int QUANTUM_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [15:0] i_req_quanta,
    input  logic        i_tx_busy,
    output logic        o_pause_active,
    output logic [15:0] o_quanta_rem
);

    localparam int PW = (QUANTUM_CYCLES > 1) ? $clog2(QUANTUM_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(QUANTUM_CYCLES - 1);

    logic          r_pending;
    logic [15:0]   r_pend_quanta;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_rem;
    logic          r_active;

    logic          w_apply;
    logic [15:0]   w_load_quanta;

    // A request arriving this cycle is newer than anything still pending.
    always_comb begin
        w_load_quanta = i_req_valid ? i_req_quanta : r_pend_quanta;
        w_apply       = (r_pending || i_req_valid) && !i_tx_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending     <= 1'b0;
            r_pend_quanta <= 16'd0;
            r_presc       <= '0;
            r_rem         <= 16'd0;
            r_active      <= 1'b0;
        end else if (w_apply) begin
            r_pending <= 1'b0;
            r_rem     <= w_load_quanta;
            r_presc   <= PRESC_MAX;
            r_active  <= (w_load_quanta != 16'd0);
        end else begin
            if (i_req_valid) begin
                r_pending     <= 1'b1;
                r_pend_quanta <= i_req_quanta;
            end
            if (r_rem != 16'd0) begin
                if (r_presc == '0) begin
                    r_presc <= PRESC_MAX;
                    r_rem   <= r_rem - 16'd1;
                    if (r_rem == 16'd1) begin
                        r_active <= 1'b0;
                    end
                end else begin
                    r_presc <= r_presc - PW'(1);
                end
            end
        end
    end

    assign o_pause_active = r_active;
    assign o_quanta_rem   = r_rem;

endmodule

// File: rtl/pause_frame_rx.sv
// Parses the receive byte stream for 802.3x PAUSE frames and hands accepted
// quanta to pause_timer, which throttles the transmitter at frame boundaries.
module pause_frame_rx
    import eth_pkg::*;
#(
    parameter int          QUANTUM_CYCLES = 64,
    parameter bit          ACCEPT_UCAST   = 1'b0,
    parameter logic [47:0] STATION_ADDR   = 48'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_err,
    input  logic        tx_busy,
    output logic        pause_active,
    output logic [15:0] pause_quanta_rem,
    output logic        pause_rcvd,
    output logic [47:0] pause_src_addr
);

    rx_state_t   r_state;
    logic [5:0]  r_idx;
    logic        r_pda_ok;
    logic        r_uda_ok;
    logic        r_hdr_ok;
    logic [47:0] r_sa;
    logic [15:0] r_quanta;
    logic        r_pause_rcvd;
    logic [47:0] r_src_addr;

    logic        w_take;
    logic        w_first;
    logic        w_pda_cur;
    logic        w_uda_cur;
    logic        w_hdr_cur;
    logic        w_pda_next;
    logic        w_uda_next;
    logic        w_hdr_next;
    logic        w_match_next;
    logic [15:0] w_quanta_next;
    logic        w_accept;

    // DA may match either the PAUSE multicast or (optionally) our own address;
    // the frame stays alive while at least one candidate still agrees.
    always_comb begin
        w_take     = rx_valid && (r_state != ST_DROP);
        w_first    = (r_state == ST_IDLE);
        w_pda_cur  = w_first ? 1'b1 : r_pda_ok;
        w_uda_cur  = w_first ? ACCEPT_UCAST : r_uda_ok;
        w_hdr_cur  = w_first ? 1'b1 : r_hdr_ok;
        w_pda_next = w_pda_cur;
        w_uda_next = w_uda_cur;
        w_hdr_next = w_hdr_cur;
        if (r_idx < 6'd6) begin
            w_pda_next = w_pda_cur && (rx_data == addr_byte(PAUSE_DA, r_idx[2:0]));
            w_uda_next = w_uda_cur && (rx_data == addr_byte(STATION_ADDR, r_idx[2:0]));
        end
        if ((r_idx >= 6'd12) && (r_idx <= 6'd15)) begin
            w_hdr_next = w_hdr_cur && (rx_data == hdr_byte(r_idx[1:0]));
        end
        w_match_next  = (w_pda_next || w_uda_next) && w_hdr_next;
        w_quanta_next = ((r_idx == 6'd16) || (r_idx == 6'd17)) ? {r_quanta[7:0], rx_data} : r_quanta;
        w_accept      = w_take && rx_last && w_match_next && (r_idx >= 6'd17) && !rx_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= 6'd0;
            r_pda_ok     <= 1'b0;
            r_uda_ok     <= 1'b0;
            r_hdr_ok     <= 1'b0;
            r_sa         <= 48'd0;
            r_quanta     <= 16'd0;
            r_pause_rcvd <= 1'b0;
            r_src_addr   <= 48'd0;
        end else begin
            r_pause_rcvd <= w_accept;
            if (w_accept) begin
                r_src_addr <= r_sa;
            end
            if (rx_valid) begin
                if (rx_last) begin
                    r_idx <= 6'd0;
                end else if (r_idx != 6'd63) begin
                    r_idx <= r_idx + 6'd1;
                end
                case (r_state)
                    ST_IDLE, ST_PARSE: begin
                        r_pda_ok <= w_pda_next;
                        r_uda_ok <= w_uda_next;
                        r_hdr_ok <= w_hdr_next;
                        r_quanta <= w_quanta_next;
                        if ((r_idx >= 6'd6) && (r_idx <= 6'd11)) begin
                            r_sa <= {r_sa[39:0], rx_data};
                        end
                        if (rx_last) begin
                            r_state <= ST_IDLE;
                        end else if (!w_match_next) begin
                            r_state <= ST_DROP;
                        end else begin
                            r_state <= ST_PARSE;
                        end
                    end
                    ST_DROP: begin
                        if (rx_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    pause_timer #(
        .QUANTUM_CYCLES(QUANTUM_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (w_accept),
        .i_req_quanta  (w_quanta_next),
        .i_tx_busy     (tx_busy),
        .o_pause_active(pause_active),
        .o_quanta_rem  (pause_quanta_rem)
    );

    assign pause_rcvd     = r_pause_rcvd;
    assign pause_src_addr = r_src_addr;

endmodule

// File: tb/tb_pause_frame_rx.sv
// Self-checking bench for pause_frame_rx: frame-level accept model plus an
// arithmetic model of the pause window (Q quanta of QC cycles from apply).
module tb_pause_frame_rx;

    localparam int          QC  = 64;
    localparam logic [47:0] PDA = 48'h0180C2000001;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_last  = 1'b0;
    logic        rx_err   = 1'b0;
    logic        tx_busy  = 1'b0;
    logic        pause_active;
    logic [15:0] pause_quanta_rem;
    logic        pause_rcvd;
    logic [47:0] pause_src_addr;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  frm[$];
    logic        frm_err = 1'b0;

    always #5 clk = ~clk;

    pause_frame_rx #(.QUANTUM_CYCLES(QC)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_last         (rx_last),
        .rx_err          (rx_err),
        .tx_busy         (tx_busy),
        .pause_active    (pause_active),
        .pause_quanta_rem(pause_quanta_rem),
        .pause_rcvd      (pause_rcvd),
        .pause_src_addr  (pause_src_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic build_frame(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] etype,
                               input logic [15:0] opc, input logic [15:0] q, input int len);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(sa[47-8*i -: 8]);
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        frm.push_back(opc[15:8]);   frm.push_back(opc[7:0]);
        frm.push_back(q[15:8]);     frm.push_back(q[7:0]);
        while (frm.size() < len) frm.push_back(8'($urandom));
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    // Gaps carry junk, including a stray rx_last, which the DUT must ignore.
    task automatic send_frame(input int gap_pct);
        $display("frame len=%0d err=%0b gap_pct=%0d", frm.size(), frm_err, gap_pct);
        for (int i = 0; i < frm.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                rx_valid = 1'b0;
                rx_last  = 1'($urandom_range(1));
                rx_err   = 1'($urandom_range(1));
                rx_data  = 8'($urandom);
                tick();
            end
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = (i == frm.size() - 1);
            rx_err   = rx_last ? frm_err : 1'($urandom_range(1));
            tick();
        end
        idle_inputs();
    endtask

    function automatic bit model_accept();
        if (frm.size() < 18 || frm_err) return 1'b0;
        for (int i = 0; i < 6; i++) if (frm[i] != PDA[47-8*i -: 8]) return 1'b0;
        if ({frm[12], frm[13]} != 16'h8808) return 1'b0;
        if ({frm[14], frm[15]} != 16'h0001) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [47:0] model_sa();
        return {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
    endfunction

    // Quanta remaining k cycles after the apply edge for a load of q.
    function automatic int exp_rem(input int q, input int k);
        if (k > q * QC) return 0;
        return q - (k - 1) / QC;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({pause_active, pause_quanta_rem, pause_rcvd} !== 18'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%0h want=0", {pause_active, pause_quanta_rem, pause_rcvd});
        end
        total++;
        if (pause_src_addr !== 48'd0) begin
            bad++;
            $display("FAIL reset_src got=%0h want=0", pause_src_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_valid_pause();
        logic [47:0] sa;
        int          len;
        sa = {16'($urandom), 32'($urandom)};
        build_frame(PDA, sa, 16'h8808, 16'h0001, 16'd3, 18 + int'($urandom_range(4)));
        frm_err = 1'b0;
        tx_busy = 1'b0;
        send_frame(20);
        len = 0;
        for (int k = 1; k <= 3 * QC + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if ({pause_rcvd, pause_src_addr} !== {1'b1, sa}) begin
                    bad++;
                    $display("FAIL valid_rcvd got=%0h want=%0h", {pause_rcvd, pause_src_addr}, {1'b1, sa});
                end
            end
            if (pause_active === 1'b1) len++;
            total++;
            if ({pause_active, pause_quanta_rem} !== {k <= 3 * QC, 16'(exp_rem(3, k))}) begin
                bad++;
                $display("FAIL valid_window k=%0d got=%0h want=%0h", k,
                         {pause_active, pause_quanta_rem}, {k <= 3 * QC, 16'(exp_rem(3, k))});
            end
        end
        total++;
        if (len != 3 * QC) begin
            bad++;
            $display("FAIL valid_duration got=%0d want=%0d", len, 3 * QC);
        end
        tick();
    endtask

    // Wrong ethertype, wrong opcode, FCS error, 17-byte runt: all silently dropped.
    task automatic test_rejects();
        for (int v = 0; v < 4; v++) begin
            build_frame(PDA, 48'h001122334455, (v == 0) ? 16'h0800 : 16'h8808,
                        (v == 1) ? 16'h0002 : 16'h0001, 16'd5, (v == 3) ? 17 : 20);
            frm_err = (v == 2);
            send_frame(10);
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                total++;
                if ({pause_rcvd, pause_active, pause_quanta_rem} !== 18'd0) begin
                    bad++;
                    $display("FAIL reject_%0d k=%0d got=%0h want=0", v, k,
                             {pause_rcvd, pause_active, pause_quanta_rem});
                end
            end
            tick();
        end
        frm_err = 1'b0;
    endtask

    task automatic test_tx_busy();
        tx_busy = 1'b1;
        repeat (10) tick();
        build_frame(PDA, 48'hA0B0C0D0E0F0, 16'h8808, 16'h0001, 16'd1, 18);
        send_frame(0);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            total++;
            if ({pause_rcvd, pause_active, pause_quanta_rem} !== {i == 0, 17'd0}) begin
                bad++;
                $display("FAIL busy_hold i=%0d got=%0h want=%0h", i,
                         {pause_rcvd, pause_active, pause_quanta_rem}, {i == 0, 17'd0});
            end
            tick();
        end
        tx_busy = 1'b0;
        @(negedge clk);
        total++;
        if (pause_active !== 1'b0) begin
            bad++;
            $display("FAIL busy_release_early got=%0b want=0", pause_active);
        end
        for (int k = 1; k <= QC + 3; k++) begin
            @(negedge clk);
            total++;
            if ({pause_active, pause_quanta_rem} !== {k <= QC, 16'(exp_rem(1, k))}) begin
                bad++;
                $display("FAIL busy_window k=%0d got=%0h want=%0h", k,
                         {pause_active, pause_quanta_rem}, {k <= QC, 16'(exp_rem(1, k))});
            end
        end
        tick();
    endtask

    task automatic test_override();
        build_frame(PDA, 48'h0203040506A7, 16'h8808, 16'h0001, 16'd10, 18);
        send_frame(0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            total++;
            if ({pause_active, pause_quanta_rem} !== {1'b1, 16'(exp_rem(10, k))}) begin
                bad++;
                $display("FAIL ovr_q10 k=%0d got=%0h want=%0h", k,
                         {pause_active, pause_quanta_rem}, {1'b1, 16'(exp_rem(10, k))});
            end
        end
        tick();
        build_frame(PDA, 48'h0203040506A8, 16'h8808, 16'h0001, 16'd2, 18);
        send_frame(0);
        for (int k = 1; k <= 2 * QC + 3; k++) begin
            @(negedge clk);
            total++;
            if ({pause_active, pause_quanta_rem} !== {k <= 2 * QC, 16'(exp_rem(2, k))}) begin
                bad++;
                $display("FAIL ovr_q2 k=%0d got=%0h want=%0h", k,
                         {pause_active, pause_quanta_rem}, {k <= 2 * QC, 16'(exp_rem(2, k))});
            end
        end
        tick();
        build_frame(PDA, 48'h0203040506A9, 16'h8808, 16'h0001, 16'd5, 18);
        send_frame(0);
        repeat (30) tick();
        @(negedge clk);
        total++;
        if (pause_active !== 1'b1) begin
            bad++;
            $display("FAIL ovr_q5_active got=%0b want=1", pause_active);
        end
        tick();
        build_frame(PDA, 48'h0203040506AA, 16'h8808, 16'h0001, 16'd0, 18);
        send_frame(0);
        @(negedge clk);
        total++;
        if ({pause_rcvd, pause_active, pause_quanta_rem} !== {1'b1, 17'd0}) begin
            bad++;
            $display("FAIL ovr_q0 got=%0h want=%0h", {pause_rcvd, pause_active, pause_quanta_rem}, {1'b1, 17'd0});
        end
        tick();
    endtask

    // A rejected frame followed immediately (no idle byte) by a good one.
    task automatic test_back_to_back();
        build_frame(PDA, 48'h111111111111, 16'h8808, 16'h0002, 16'd3, 19);
        send_frame(0);
        build_frame(PDA, 48'h222222222222, 16'h8808, 16'h0001, 16'd1, 18);
        send_frame(0);
        for (int k = 1; k <= QC + 2; k++) begin
            @(negedge clk);
            total++;
            if ({pause_active, pause_quanta_rem} !== {k <= QC, 16'(exp_rem(1, k))}) begin
                bad++;
                $display("FAIL b2b k=%0d got=%0h want=%0h", k,
                         {pause_active, pause_quanta_rem}, {k <= QC, 16'(exp_rem(1, k))});
            end
        end
        tick();
    endtask

    task automatic test_random();
        int          q;
        int          kind;
        int          eq;
        bit          exp_acc;
        logic [47:0] sa;
        for (int n = 0; n < 30; n++) begin
            q    = 1 + int'($urandom_range(1));
            kind = int'($urandom_range(5));
            sa   = {16'($urandom), 32'($urandom)};
            build_frame(PDA, sa, 16'h8808, 16'h0001, 16'(q), 18 + int'($urandom_range(6)));
            frm_err = 1'b0;
            case (kind)
                1: frm[$urandom_range(5)]       ^= 8'(1 + $urandom_range(254));
                2: frm[12 + $urandom_range(1)]  ^= 8'(1 + $urandom_range(254));
                3: frm[14 + $urandom_range(1)]  ^= 8'(1 + $urandom_range(254));
                4: frm_err = 1'b1;
                5: build_frame(PDA, sa, 16'h8808, 16'h0001, 16'(q), 12 + int'($urandom_range(5)));
                default: ;
            endcase
            exp_acc = model_accept();
            send_frame(int'($urandom_range(25)));
            eq = exp_acc ? q : 0;
            for (int k = 1; k <= eq * QC + 2; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    total++;
                    if (pause_rcvd !== exp_acc) begin
                        bad++;
                        $display("FAIL rand_rcvd n=%0d kind=%0d got=%0b want=%0b", n, kind, pause_rcvd, exp_acc);
                    end
                    if (exp_acc) begin
                        total++;
                        if (pause_src_addr !== model_sa()) begin
                            bad++;
                            $display("FAIL rand_sa n=%0d got=%0h want=%0h", n, pause_src_addr, model_sa());
                        end
                    end
                end
                total++;
                if ({pause_active, pause_quanta_rem} !== {k <= eq * QC, 16'(exp_rem(eq, k))}) begin
                    bad++;
                    $display("FAIL rand_window n=%0d k=%0d got=%0h want=%0h", n, k,
                             {pause_active, pause_quanta_rem}, {k <= eq * QC, 16'(exp_rem(eq, k))});
                end
            end
            tick();
        end
        frm_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [47:0] sa;
        sa = {16'($urandom), 32'($urandom)};
        build_frame(PDA, sa, 16'h8808, 16'h0001, 16'd2, 18);
        for (int i = 0; i < 9; i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = 1'b0;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({pause_rcvd, pause_active, pause_quanta_rem, pause_src_addr} !== 66'd0) begin
            bad++;
            $display("FAIL rst_frame got=%0h want=0", {pause_rcvd, pause_active, pause_quanta_rem, pause_src_addr});
        end
        rst = 1'b0;
        tick();
        send_frame(10);
        @(negedge clk);
        total++;
        if ({pause_rcvd, pause_active, pause_quanta_rem, pause_src_addr} !== {2'b11, 16'd2, sa}) begin
            bad++;
            $display("FAIL rst_next_frame got=%0h want=%0h",
                     {pause_rcvd, pause_active, pause_quanta_rem, pause_src_addr}, {2'b11, 16'd2, sa});
        end
        repeat (50) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({pause_rcvd, pause_active, pause_quanta_rem, pause_src_addr} !== 66'd0) begin
            bad++;
            $display("FAIL rst_pause got=%0h want=0", {pause_rcvd, pause_active, pause_quanta_rem, pause_src_addr});
        end
        rst = 1'b0;
        tx_busy = 1'b1;
        tick();
        build_frame(PDA, sa, 16'h8808, 16'h0001, 16'd4, 18);
        send_frame(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_busy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            @(negedge clk);
            total++;
            if ({pause_active, pause_quanta_rem} !== 17'd0) begin
                bad++;
                $display("FAIL rst_pending k=%0d got=%0h want=0", k, {pause_active, pause_quanta_rem});
            end
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_valid_pause();
        test_rejects();
        test_tx_busy();
        test_override();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
